// File: rtl/offset_sweep_scheduler_pkg.sv
// Shared types and helpers for the offset sweep scheduler: FSM states,
// configuration field codes and the saturating offset adder.
package offset_sweep_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [1:0] FLD_PHASE  = 2'd0;
   localparam logic [1:0] FLD_FSTART = 2'd1;
   localparam logic [1:0] FLD_FSTEP  = 2'd2;
   localparam logic [1:0] FLD_LEN    = 2'd3;

   localparam int SAT_W = 64;

   // Operands arrive sign-extended to SAT_W; the result is clamped to the
   // signed range of an ofs_w-bit value so callers can simply truncate.
   function automatic logic signed [SAT_W-1:0] sat_add(
      input logic signed [SAT_W-1:0] a,
      input logic signed [SAT_W-1:0] b,
      input int                      ofs_w
   );
      logic signed [SAT_W:0] sum;
      logic signed [SAT_W:0] one;
      logic signed [SAT_W:0] hi;
      logic signed [SAT_W:0] lo;
      one = {{SAT_W{1'b0}}, 1'b1};
      sum = {a[SAT_W-1], a} + {b[SAT_W-1], b};
      hi  = (one <<< (ofs_w - 1)) - one;
      lo  = -(one <<< (ofs_w - 1));
      if (sum > hi) begin
         sum = hi;
      end else if (sum < lo) begin
         sum = lo;
      end
      return sum[SAT_W-1:0];
   endfunction

endpackage

// File: rtl/offset_sweep_scheduler_strobe_divider.sv
// Sample-cadence divider: counts 1..OVERCLK_FACTOR and flags the count-1 cycle
// as the source sample strobe.
module strobe_divider
   import offset_sweep_pkg::*;
#(
   parameter int OVERCLK_FACTOR = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clr,
   input  logic i_en,
   output logic o_strobe
);

   localparam int CNT_W = $clog2(OVERCLK_FACTOR + 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OVERCLK_FACTOR);

   logic [CNT_W-1:0] r_div_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_div_cnt <= CNT_ONE;
      end else if (i_clr) begin
         r_div_cnt <= CNT_ONE;
      end else if (i_en) begin
         r_div_cnt <= (r_div_cnt == CNT_MAX) ? CNT_ONE : r_div_cnt + CNT_ONE;
      end
   end

   assign o_strobe = (r_div_cnt == CNT_ONE);

endmodule

// File: rtl/offset_sweep_scheduler.sv
// Offset sweep scheduler: walks a table of ramp segments, strobing the DPI source
// every OVERCLK_FACTOR enabled clocks and stepping its frequency offset per sample.
module offset_sweep_scheduler
   import offset_sweep_pkg::*;
#(
   parameter int  OVERCLK_FACTOR = 5,
   parameter int  OFS_W          = 24,
   parameter int  LEN_W          = 16,
   parameter int  NUM_SEG        = 4,
   localparam int SEG_W          = $clog2(NUM_SEG)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clk_enable,
   input  logic                    cfg_we,
   input  logic [SEG_W-1:0]        cfg_addr,
   input  logic [1:0]              cfg_field,
   input  logic [OFS_W-1:0]        cfg_data,
   input  logic [SEG_W:0]          num_seg,
   input  logic                    start,
   input  logic                    abort,
   output logic                    src_strobe,
   output logic signed [OFS_W-1:0] phase_offset,
   output logic signed [OFS_W-1:0] freq_offset,
   output logic [SEG_W-1:0]        seg_idx,
   output logic                    busy,
   output logic                    done
);

   localparam logic [SEG_W-1:0] SEG_ONE  = SEG_W'(1);
   localparam logic [SEG_W:0]   NSEG_MAX = (SEG_W + 1)'(NUM_SEG);
   localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

   state_t r_state;
   state_t w_state_nxt;

   logic [SEG_W:0]          r_num_seg;
   logic [SEG_W-1:0]        r_seg_idx;
   logic [LEN_W-1:0]        r_len_cnt;
   logic signed [OFS_W-1:0] r_phase;
   logic signed [OFS_W-1:0] r_freq;
   logic signed [OFS_W-1:0] r_step;

   logic signed [OFS_W-1:0] r_tbl_phase  [NUM_SEG];
   logic signed [OFS_W-1:0] r_tbl_fstart [NUM_SEG];
   logic signed [OFS_W-1:0] r_tbl_fstep  [NUM_SEG];
   logic [LEN_W-1:0]        r_tbl_len    [NUM_SEG];

   logic [SEG_W-1:0]        w_rd_addr;
   logic signed [OFS_W-1:0] w_rd_phase;
   logic signed [OFS_W-1:0] w_rd_fstart;
   logic signed [OFS_W-1:0] w_rd_fstep;
   logic [LEN_W-1:0]        w_rd_len;

   logic [SEG_W:0]          w_cand;
   logic [SEG_W-1:0]        w_nxt_seg;
   logic                    w_nxt_found;
   logic                    w_seg_last;
   logic signed [OFS_W-1:0] w_freq_sum;

   logic w_div_strobe;
   logic w_div_clr;
   logic w_div_en;
   logic w_strobe;
   logic w_done;
   logic w_tbl_we;
   logic w_capture;
   logic w_seg_skip;
   logic w_seg_load;
   logic w_step;

   strobe_divider #(
      .OVERCLK_FACTOR(OVERCLK_FACTOR)
   ) u_div (
      .clk     (clk),
      .reset   (reset),
      .i_clr   (w_div_clr),
      .i_en    (w_div_en),
      .o_strobe(w_div_strobe)
   );

   // Nearest following non-empty segment within the run, so a segment boundary
   // in RUN can hop over zero-length entries without losing a strobe slot.
   always_comb begin
      w_cand      = '0;
      w_nxt_seg   = '0;
      w_nxt_found = 1'b0;
      for (int k = NUM_SEG - 1; k >= 1; k--) begin
         w_cand = {1'b0, r_seg_idx} + (SEG_W + 1)'(k);
         if ((w_cand < r_num_seg) && (r_tbl_len[w_cand[SEG_W-1:0]] != '0)) begin
            w_nxt_found = 1'b1;
            w_nxt_seg   = w_cand[SEG_W-1:0];
         end
      end
   end

   assign w_seg_last  = (({1'b0, r_seg_idx} + (SEG_W + 1)'(1)) >= r_num_seg);
   assign w_rd_addr   = (r_state == ST_LOAD) ? r_seg_idx : w_nxt_seg;
   assign w_rd_phase  = r_tbl_phase[w_rd_addr];
   assign w_rd_fstart = r_tbl_fstart[w_rd_addr];
   assign w_rd_fstep  = r_tbl_fstep[w_rd_addr];
   assign w_rd_len    = r_tbl_len[w_rd_addr];
   assign w_freq_sum  = OFS_W'(sat_add(SAT_W'(r_freq), SAT_W'(r_step), OFS_W));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_strobe    = 1'b0;
      w_done      = 1'b0;
      w_tbl_we    = 1'b0;
      w_capture   = 1'b0;
      w_seg_skip  = 1'b0;
      w_seg_load  = 1'b0;
      w_step      = 1'b0;
      w_div_clr   = 1'b0;
      w_div_en    = 1'b0;
      if (clk_enable) begin
         case (r_state)
            ST_IDLE: begin
               w_tbl_we = cfg_we;
               if (start) begin
                  w_capture   = 1'b1;
                  w_state_nxt = ((num_seg == '0) || (num_seg > NSEG_MAX)) ? ST_DONE : ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (abort) begin
                  w_state_nxt = ST_IDLE;
               end else if (w_rd_len == '0) begin
                  if (w_seg_last) begin
                     w_state_nxt = ST_DONE;
                  end else begin
                     w_seg_skip = 1'b1;
                  end
               end else begin
                  w_seg_load  = 1'b1;
                  w_div_clr   = 1'b1;
                  w_state_nxt = ST_RUN;
               end
            end
            ST_RUN: begin
               // abort takes priority over a pending strobe
               if (abort) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_div_en = 1'b1;
                  w_strobe = w_div_strobe;
                  if (w_div_strobe) begin
                     if (r_len_cnt == LEN_ONE) begin
                        if (w_nxt_found) begin
                           w_seg_load = 1'b1;
                        end else begin
                           w_state_nxt = ST_DONE;
                        end
                     end else begin
                        w_step = 1'b1;
                     end
                  end
               end
            end
            ST_DONE: begin
               w_done      = 1'b1;
               w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_SEG; i++) begin
            r_tbl_phase[i]  <= '0;
            r_tbl_fstart[i] <= '0;
            r_tbl_fstep[i]  <= '0;
            r_tbl_len[i]    <= '0;
         end
      end else if (w_tbl_we) begin
         case (cfg_field)
            FLD_PHASE:  r_tbl_phase[cfg_addr]  <= cfg_data;
            FLD_FSTART: r_tbl_fstart[cfg_addr] <= cfg_data;
            FLD_FSTEP:  r_tbl_fstep[cfg_addr]  <= cfg_data;
            FLD_LEN:    r_tbl_len[cfg_addr]    <= cfg_data[LEN_W-1:0];
         endcase
      end
   end

   // Offsets only move on a segment load or a mid-segment strobe, so they are
   // stable throughout every strobe cycle and hold after DONE or abort.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_num_seg <= '0;
         r_seg_idx <= '0;
         r_len_cnt <= '0;
         r_phase   <= '0;
         r_freq    <= '0;
         r_step    <= '0;
      end else begin
         if (w_capture) begin
            r_num_seg <= num_seg;
            r_seg_idx <= '0;
         end
         if (w_seg_skip) begin
            r_seg_idx <= r_seg_idx + SEG_ONE;
         end
         if (w_seg_load) begin
            r_seg_idx <= w_rd_addr;
            r_phase   <= w_rd_phase;
            r_freq    <= w_rd_fstart;
            r_step    <= w_rd_fstep;
            r_len_cnt <= w_rd_len;
         end else if (w_step) begin
            r_freq    <= w_freq_sum;
            r_len_cnt <= r_len_cnt - LEN_ONE;
         end
      end
   end

   assign src_strobe   = w_strobe;
   assign done         = w_done;
   assign busy         = (r_state == ST_LOAD) || (r_state == ST_RUN);
   assign phase_offset = r_phase;
   assign freq_offset  = r_freq;
   assign seg_idx      = r_seg_idx;

endmodule

// File: tb/tb_offset_sweep_scheduler.sv
// Randomized bench for offset_sweep_scheduler: a segment-list reference model
// predicts strobe times, offsets and completion in enabled-clock time.
module tb_offset_sweep_scheduler;

   localparam int     OC    = 5;
   localparam int     OFS_W = 24;
   localparam int     LEN_W = 16;
   localparam int     NSEG  = 4;
   localparam int     SEG_W = 2;
   localparam longint MAXV  = 64'sd8388607;
   localparam longint MINV  = -64'sd8388608;

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    clk_enable;
   logic                    cfg_we;
   logic [SEG_W-1:0]        cfg_addr;
   logic [1:0]              cfg_field;
   logic [OFS_W-1:0]        cfg_data;
   logic [SEG_W:0]          num_seg;
   logic                    start;
   logic                    abort;
   logic                    src_strobe;
   logic signed [OFS_W-1:0] phase_offset;
   logic signed [OFS_W-1:0] freq_offset;
   logic [SEG_W-1:0]        seg_idx;
   logic                    busy;
   logic                    done;

   offset_sweep_scheduler #(
      .OVERCLK_FACTOR(OC),
      .OFS_W         (OFS_W),
      .LEN_W         (LEN_W),
      .NUM_SEG       (NSEG)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .clk_enable  (clk_enable),
      .cfg_we      (cfg_we),
      .cfg_addr    (cfg_addr),
      .cfg_field   (cfg_field),
      .cfg_data    (cfg_data),
      .num_seg     (num_seg),
      .start       (start),
      .abort       (abort),
      .src_strobe  (src_strobe),
      .phase_offset(phase_offset),
      .freq_offset (freq_offset),
      .seg_idx     (seg_idx),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int     t;
      longint ph;
      longint fr;
      int     seg;
   } ev_t;

   ev_t    evq[$];
   int     done_t;
   longint m_ph[NSEG];
   longint m_fs[NSEG];
   longint m_st[NSEG];
   int     m_len[NSEG];
   longint cur_ph;
   longint cur_fr;
   bit     cur_known;
   int     n_checks = 0;
   int     n_fail   = 0;

   task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic longint sat(input longint v);
      if (v > MAXV) return MAXV;
      if (v < MINV) return MINV;
      return v;
   endfunction

   function automatic longint sx(input logic [OFS_W-1:0] v);
      return longint'($signed(v));
   endfunction

   function automatic logic [OFS_W-1:0] rnd_ofs();
      case ($urandom_range(0, 3))
         0:       return OFS_W'($urandom);
         1:       return OFS_W'($urandom_range(0, 200)) - OFS_W'(100);
         2:       return 24'h7FFFFF - OFS_W'($urandom_range(0, 20));
         default: return 24'h800000 + OFS_W'($urandom_range(0, 20));
      endcase
   endfunction

   // Expected strobes: leading empty segments each cost one LOAD cycle, later
   // empty ones are skipped with no gap; strobes are OC enabled cycles apart.
   task automatic build_model(input int n);
      int     t;
      int     z;
      longint f;
      ev_t    ev;
      evq.delete();
      if (n < 1 || n > NSEG) begin
         done_t = 1;
         return;
      end
      z = 0;
      while (z < n && m_len[z] == 0) z++;
      if (z == n) begin
         done_t = n + 1;
         return;
      end
      t = z + 2;
      for (int s = z; s < n; s++) begin
         f = m_fs[s];
         for (int k = 0; k < m_len[s]; k++) begin
            ev.t   = t;
            ev.ph  = m_ph[s];
            ev.fr  = f;
            ev.seg = s;
            evq.push_back(ev);
            f = sat(f + m_st[s]);
            t += OC;
         end
      end
      done_t = t - OC + 1;
   endtask

   task automatic wr(input int a, input int f, input logic [OFS_W-1:0] d);
      tick();
      clk_enable = 1'b1;
      cfg_we     = 1'b1;
      cfg_addr   = SEG_W'(a);
      cfg_field  = 2'(f);
      cfg_data   = d;
      start      = 1'b0;
      abort      = 1'b0;
      case (f)
         0:       m_ph[a] = sx(d);
         1:       m_fs[a] = sx(d);
         2:       m_st[a] = sx(d);
         default: m_len[a] = int'(d[LEN_W-1:0]);
      endcase
   endtask

   task automatic set_seg(input int a, input longint ph, input longint fs, input longint st, input int len);
      wr(a, 0, OFS_W'(ph));
      wr(a, 1, OFS_W'(fs));
      wr(a, 2, OFS_W'(st));
      wr(a, 3, {8'($urandom), 16'(len)});
   endtask

   task automatic run_txn(input int n, input int abort_ev, input bit rand_en);
      int  e;
      int  ev_i;
      int  guard;
      int  abort_e;
      int  end_e;
      bit  en;
      bit  exp_stb;
      bit  nz;
      build_model(n);
      nz = 1'b0;
      for (int s = 0; s < NSEG; s++) begin
         if (s < n && (m_ph[s] != 0 || m_fs[s] != 0)) nz = 1'b1;
      end
      if (evq.size() == 0 && n >= 1 && n <= NSEG && nz) cur_known = 1'b0;
      abort_e = -1;
      if (abort_ev >= 0 && abort_ev < evq.size()) abort_e = evq[abort_ev].t;
      end_e = (abort_e >= 0) ? abort_e : done_t;
      e     = 0;
      ev_i  = 0;
      guard = 0;
      while (e <= end_e && guard < 2000) begin
         tick();
         guard++;
         en         = (e == 0) || !rand_en || ($urandom_range(0, 3) != 0);
         clk_enable = en;
         start      = (e == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         num_seg    = (e == 0) ? (SEG_W + 1)'(n) : (SEG_W + 1)'($urandom);
         if (en && e == abort_e) abort = 1'b1;
         else if (en && e > 0 && e < end_e) abort = 1'b0;
         else abort = 1'($urandom_range(0, 1));
         cfg_we    = (e == 0) ? 1'b0 : 1'($urandom_range(0, 1));
         cfg_addr  = SEG_W'($urandom);
         cfg_field = 2'($urandom);
         cfg_data  = OFS_W'($urandom);
         #1;
         chk("busy", busy, (e >= 1) && (e < done_t));
         if (en) begin
            exp_stb = (ev_i < evq.size()) && (evq[ev_i].t == e) && (e != abort_e);
            chk("strobe", src_strobe, exp_stb);
            chk("done", done, (e == done_t) && (abort_e < 0));
            if (exp_stb) begin
               chk("phase", phase_offset, evq[ev_i].ph);
               chk("freq", freq_offset, evq[ev_i].fr);
               chk("seg_idx", seg_idx, evq[ev_i].seg);
            end
            if (ev_i < evq.size() && evq[ev_i].t == e) begin
               cur_ph    = evq[ev_i].ph;
               cur_fr    = evq[ev_i].fr;
               cur_known = 1'b1;
               ev_i++;
            end
            e++;
         end else begin
            chk("strobe_gated", src_strobe, 0);
            chk("done_gated", done, 0);
         end
      end
      chk("txn_end", e, end_e + 1);
      repeat (2) begin
         tick();
         clk_enable = 1'b1;
         start      = 1'b0;
         abort      = 1'b0;
         cfg_we     = 1'b0;
         #1;
         chk("idle_busy", busy, 0);
         chk("idle_done", done, 0);
         chk("idle_strobe", src_strobe, 0);
         if (cur_known) begin
            chk("hold_phase", phase_offset, cur_ph);
            chk("hold_freq", freq_offset, cur_fr);
         end
      end
   endtask

   task automatic clear_model();
      for (int s = 0; s < NSEG; s++) begin
         m_ph[s]  = 0;
         m_fs[s]  = 0;
         m_st[s]  = 0;
         m_len[s] = 0;
      end
      cur_ph    = 0;
      cur_fr    = 0;
      cur_known = 1'b1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_strobe"}, src_strobe, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_phase"}, phase_offset, 0);
      chk({tag, "_freq"}, freq_offset, 0);
      chk({tag, "_seg"}, seg_idx, 0);
   endtask

   initial begin
      int n;
      int ab;
      int f;
      reset      = 1'b1;
      clk_enable = 1'b0;
      cfg_we     = 1'b0;
      cfg_addr   = '0;
      cfg_field  = '0;
      cfg_data   = '0;
      num_seg    = '0;
      start      = 1'b0;
      abort      = 1'b0;
      clear_model();
      repeat (3) tick();
      chk_reset_vals("rst");
      reset = 1'b0;

      run_txn(4, -1, 1'b0);

      set_seg(0, 100, 0, 10, 3);
      run_txn(1, -1, 1'b0);

      set_seg(0, -50, 5, 1, 2);
      set_seg(1, 70, -5, -1, 2);
      run_txn(2, -1, 1'b0);

      set_seg(0, 7, MAXV - 5, 10, 3);
      run_txn(1, -1, 1'b0);

      set_seg(0, 11, 1, 1, 1);
      set_seg(1, 22, 2, 2, 0);
      set_seg(2, 33, 3, 3, 2);
      run_txn(3, -1, 1'b0);

      set_seg(0, 100, 0, 10, 3);
      run_txn(1, 1, 1'b0);

      set_seg(1, -1000, MINV + 3, -7, 2);
      run_txn(3, -1, 1'b1);
      run_txn(0, -1, 1'b1);
      run_txn(5, -1, 1'b1);

      repeat (40) begin
         repeat ($urandom_range(0, 4)) begin
            f = int'($urandom_range(0, 3));
            if (f == 3) wr(int'($urandom_range(0, NSEG - 1)), 3, {8'($urandom), 16'($urandom_range(0, 4))});
            else wr(int'($urandom_range(0, NSEG - 1)), f, rnd_ofs());
         end
         n  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(1, 4));
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1;
         run_txn(n, ab, 1'b1);
      end

      set_seg(0, 55, 66, 1, 3);
      tick();
      clk_enable = 1'b1;
      cfg_we     = 1'b0;
      abort      = 1'b0;
      start      = 1'b1;
      num_seg    = 3'd1;
      repeat (4) begin
         tick();
         start = 1'b0;
      end
      reset = 1'b1;
      #1;
      chk_reset_vals("midrst");
      tick();
      tick();
      reset = 1'b0;
      clear_model();
      run_txn(2, -1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
